// File: rtl/shift_reg_arbiter.sv
// rtl/shift_reg_arbiter.sv - round-robin arbitrated parallel-to-serial shifter for two requesters
// Grants one word at a time, shifts it out MSB-first, then idles for GAP cycles.
module shift_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             owner
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHIFT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             fstart_q, fstart_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             grant0, grant1;

  // ptr_q = 0 favours requester 0 on a tie; a lone request always wins.
  assign grant1 = req1 & (~req0 | ptr_q);
  assign grant0 = req0 & ~grant1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = {sreg_q[WIDTH-2:0], 1'b0};
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    fstart_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant0 | grant1) begin
          sreg_d   = grant1 ? data1 : data0;
          owner_d  = grant1;
          ptr_d    = ~grant1;
          cnt_d    = SHIFT_LOAD;
          ack0_d   = grant0;
          ack1_d   = grant1;
          fstart_d = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_SHIFT);
    busy_d  = (state_d != ST_IDLE);
  end

  // The shift register drains to zero by the end of a frame, so its MSB
  // doubles as sout and is already 0 whenever no frame bit is on the lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      fstart_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      fstart_q <= fstart_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign sout        = sreg_q[WIDTH-1];
  assign sout_valid  = valid_q;
  assign frame_start = fstart_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_shift_reg_arbiter.sv
// tb/tb_shift_reg_arbiter.sv - scoreboard bench for shift_reg_arbiter (GAP=1 and GAP=0 instances)
module tb_shift_reg_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, ack0, ack1, sout, sout_valid, frame_start, busy, owner;
  logic [7:0] data0, data1;
  logic g_req0, g_req1, g_ack0, g_ack1, g_sout, g_sout_valid, g_frame_start, g_busy, g_owner;
  logic [7:0] g_data0, g_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic       own;
    logic [7:0] data;
    int         nbits;
  } exp_t;

  exp_t exp_q[$];
  int   fs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_reg_arbiter #(.WIDTH(8), .GAP(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start),
    .busy(busy), .owner(owner)
  );

  shift_reg_arbiter #(.WIDTH(8), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst),
    .req0(g_req0), .data0(g_data0), .ack0(g_ack0),
    .req1(g_req1), .data1(g_data1), .ack1(g_ack1),
    .sout(g_sout), .sout_valid(g_sout_valid), .frame_start(g_frame_start),
    .busy(g_busy), .owner(g_owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic own, input logic [7:0] d, input int nb);
    exp_t e;
    e.own = own; e.data = d; e.nbits = nb;
    exp_q.push_back(e);
  endtask

  // Raise req, hold until ack is seen (bounded), then drop it.
  task automatic send(input int who, input logic [7:0] d, output int ack_cyc);
    ack_cyc = -1;
    if (who == 0) begin data0 = d; req0 = 1'b1; end
    else          begin data1 = d; req1 = 1'b1; end
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if ((who == 0 && ack0) || (who == 1 && ack1)) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    if (ack_cyc < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: requester %0d got no ack expected one", who);
    end
  endtask

  task automatic wait_idle();
    int ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (ok == 0) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stuck at 1 expected 0");
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_outs"}, {ack0, ack1, sout, sout_valid, frame_start, busy, owner}, 7'b0);
  endtask

  // Monitor: rebuilds each frame from the lane and compares it against the scoreboard.
  logic       in_frame = 1'b0;
  int         mon_nb = 0;
  logic [7:0] mon_word = '0;

  always @(negedge clk) begin
    exp_t e;
    if (in_frame && !sout_valid) begin
      in_frame = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame: got frame %0h expected none", mon_word);
      end else begin
        e = exp_q.pop_front();
        chk("frame_len", mon_nb, e.nbits);
        chk("frame_data", mon_word, e.data >> (8 - e.nbits));
      end
    end
    if (frame_start) begin
      chk("fs_valid", sout_valid, 1'b1);
      if (exp_q.size() > 0) begin
        chk("frame_owner", owner, exp_q[0].own);
        chk("ack_with_fs", {ack1, ack0}, exp_q[0].own ? 2'b10 : 2'b01);
      end
      fs_q.push_back(cyc);
      in_frame = 1'b1;
      mon_nb   = 1;
      mon_word = {7'b0, sout};
    end else begin
      chk("ack_without_fs", {ack1, ack0}, 2'b00);
      if (in_frame) begin
        mon_nb++;
        mon_word = {mon_word[6:0], sout};
      end
    end
    if (!sout_valid) chk("sout_idle_zero", sout, 1'b0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a0, a1, c0, c1;
  int gfs[$];

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    g_req0 = 0; g_req1 = 0; g_data0 = '0; g_data1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // Single request, 0xA5
    push_exp(1'b0, 8'hA5, 8);
    send(0, 8'hA5, a0);
    @(negedge clk);
    chk("t1_ack_pulse", ack0, 1'b0);
    repeat (7) @(negedge clk);
    chk("t1_gap_valid", sout_valid, 1'b0);
    chk("t1_gap_busy", busy, 1'b1);
    @(negedge clk);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_owner_hold", owner, 1'b0);

    // Simultaneous requests after reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push_exp(1'b0, 8'hFF, 8);
    push_exp(1'b1, 8'h01, 8);
    fork
      send(0, 8'hFF, a0);
      send(1, 8'h01, a1);
    join
    chk("t2_ack_spacing", a1 - a0, 10);
    wait_idle();

    // Continuous contention over four frames
    fs_q.delete();
    push_exp(1'b0, 8'h81, 8);
    push_exp(1'b1, 8'h7E, 8);
    push_exp(1'b0, 8'h55, 8);
    push_exp(1'b1, 8'hAA, 8);
    fork
      begin send(0, 8'h81, c0); send(0, 8'h55, c0); end
      begin send(1, 8'h7E, c1); send(1, 8'hAA, c1); end
    join
    wait_idle();
    chk("t3_frames", fs_q.size(), 4);
    if (fs_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t3_fs_spacing", fs_q[i] - fs_q[i-1], 10);
    end

    // Reset during the 4th bit of a frame, with req1 pending
    push_exp(1'b0, 8'h96, 4);
    send(0, 8'h96, a0);
    push_exp(1'b1, 8'h5A, 8);
    fork
      send(1, 8'h5A, a1);
      begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("t5_midreset");
      end
    join
    chk("t5_ack1_after_rst", a1 - a0, 5);
    wait_idle();

    // Request arriving during the 3rd bit of a req0 frame
    push_exp(1'b0, 8'hC3, 8);
    push_exp(1'b1, 8'h69, 8);
    send(0, 8'hC3, a0);
    repeat (2) @(posedge clk);
    #1;
    send(1, 8'h69, a1);
    chk("t6_ack1_delay", a1 - a0, 10);
    wait_idle();
    chk("t6_owner_hold", owner, 1'b1);

    // GAP=0 instance: req1 held high, back-to-back frames
    begin
      int         nb = 0;
      int         low = 0;
      logic [7:0] w = '0;
      @(negedge clk);
      g_data1 = 8'h3C;
      g_req1  = 1'b1;
      for (int i = 0; i < 45; i++) begin
        @(negedge clk);
        if (g_frame_start) begin
          gfs.push_back(cyc);
          nb = 0;
          chk("gap0_ack", g_ack1, 1'b1);
        end
        if (g_sout_valid) begin
          w = {w[6:0], g_sout};
          nb++;
          if (nb == 8) chk("gap0_word", w, 8'h3C);
        end else if (gfs.size() >= 1 && gfs.size() < 4) begin
          low++;
        end
      end
      g_req1 = 1'b0;
      chk("gap0_frames", (gfs.size() >= 4) ? 1 : 0, 1);
      if (gfs.size() >= 4) begin
        for (int i = 1; i < 4; i++) chk("gap0_fs_spacing", gfs[i] - gfs[i-1], 9);
      end
      chk("gap0_low_cycles", low, 3);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_arbiter.md
# shift_reg_arbiter

Arbitrated parallel-to-serial engine that shares one WIDTH-bit shift register between two requesters. Each requester presents a parallel word with a req/ack handshake. The block grants in round-robin order, loads the winning word, and shifts it out MSB-first, one bit per cycle. A programmable idle gap follows each frame. It sits between two word-producing clients and a single serial output lane.

## Interface
- WIDTH, 8: word and frame length in bits; must be >= 2.
- GAP, 1: idle cycles after each frame; 0 allowed.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 has a word pending.
- data0  in  WIDTH  requester 0 word; held stable while req0 is high.
- ack0  out  1  one-cycle pulse: data0 captured.
- req1  in  1  requester 1 has a word pending.
- data1  in  WIDTH  requester 1 word; held stable while req1 is high.
- ack1  out  1  one-cycle pulse: data1 captured.
- sout  out  1  serial data, MSB first; 0 when sout_valid is low.
- sout_valid  out  1  sout carries a frame bit.
- frame_start  out  1  high on the first bit of each frame.
- busy  out  1  a frame or gap is in progress.
- owner  out  1  index of the requester that owns the current frame.

## Operation
- States: IDLE, SHIFT, GAP.
- **IDLE:** if no req is high, stay. If any req is high, grant per the priority pointer:
  - Capture the granted data word into the shift register.
  - Set owner to the granted index.
  - Load the bit counter with WIDTH-1.
  - Go to SHIFT.
  - Set the priority pointer so the other requester wins the next tie.
- **Priority pointer:** after reset it favours requester 0. A lone requester always wins regardless of the pointer.
- **SHIFT:**
  - sout = shift register MSB; sout_valid = 1.
  - Each cycle the register shifts left, with 0 filled into the LSB.
  - The counter decrements each cycle.
  - At counter 0: go to GAP if GAP > 0, else go to IDLE.
- **GAP:** sout_valid = 0, busy = 1. Count GAP cycles, then go to IDLE.
- **Requests outside IDLE:** a req arriving or held during SHIFT or GAP is not sampled. It waits and is arbitrated in the next IDLE cycle.
- **Requester rules:**
  - Hold req and data until ack is seen.
  - Drop req the cycle after ack unless another word is pending.
  - A req still high on return to IDLE counts as a new request.
- **Registered outputs:** all outputs are registered. owner holds its last value while idle.
- **Reset (also mid-frame):** aborts any frame. In the cycle after rst is sampled:
  - ack0, ack1, sout, sout_valid, frame_start and busy are 0.
  - owner = 0, state = IDLE, pointer favours requester 0.
  - The shift register is cleared.
  - Aborted words are not re-sent; the requester already received its ack.

## Timing
- Grant edge N (IDLE with a req sampled). Then:
  - In cycle N+1: ackX = 1, frame_start = 1, sout_valid = 1, sout = data bit WIDTH-1, busy = 1.
- Bit k (WIDTH-1 down to 0) appears in cycle N+WIDTH-k.
- Last bit (LSB) appears in cycle N+WIDTH.
- Gap occupies cycles N+WIDTH+1 .. N+WIDTH+GAP, with busy = 1 and sout_valid = 0.
- In cycle N+WIDTH+GAP+1: busy = 0, state = IDLE. The next grant edge can be that cycle.
- Minimum spacing between frame_start pulses is WIDTH+GAP+1 cycles.
- ack, frame_start and the first sout_valid always coincide.
- Exactly one ack is asserted per frame.

## Test plan
- **Single request:** WIDTH=8, GAP=1; req0=1, data0=0xA5 at grant edge N -> ack0 in N+1 only. sout over N+1..N+8 = 1,0,1,0,0,1,0,1 with sout_valid high. busy low at N+10.
- **Simultaneous requests after reset:** req0 and req1 raised together with data0=0xFF, data1=0x01 -> requester 0 served first (owner=0). Requester 1 acked in cycle N+11, and its frame outputs 0000_0001.
- **Continuous contention:** req0 and req1 held high for four frames -> owner sequence 0,1,0,1. frame_start spacing exactly 10 cycles with GAP=1.
- **Back-to-back, no gap:** GAP=0; req1 held high, data1=0x3C -> frame_start every 9 cycles. sout_valid low exactly one cycle between frames.
- **Reset mid-frame:** rst asserted during the 4th bit of a frame -> next cycle all outputs 0, state IDLE. With req1 pending, req1 granted on the first edge after rst deasserts, and its ack1 pulses.
- **Request arriving while busy:** req1 raised in the 3rd bit of a req0 frame -> no ack1 until the frame and gap complete. ack1 in cycle N+WIDTH+GAP+2.
